// File: rtl/snoop_cache_controller.sv
// Purpose   : per-CPU 4-line direct-mapped MSI write-back cache controller on a two-CPU snooping bus.
// Latency   : hit -> done 2 cycles after strobe; miss -> done 1 cycle after the accepting fill edge.
// Backpress.: requests taken only in IDLE; a snoop SUPPLY owns bus_out for 3 cycles and own packets wait.
// Ports     : clock/reset (async, active-high); bus_in = fill replies and forwarded snoops;
//             execute_instruction/instruction/address/data_in = local request; data_out/done = result;
//             bus_out = {WB,SUPPLY,BCAST,RD_MISS,WR_MISS,INV,addr[2:0],data[3:0]}.
module snoop_cache_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic [12:0] bus_in,
    input  logic        execute_instruction,
    input  logic        instruction,
    input  logic [2:0]  address,
    input  logic [3:0]  data_in,
    output logic [3:0]  data_out,
    output logic        done,
    output logic [12:0] bus_out
);
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB_WAIT, S_MISS_WAIT, S_FINISH} state_t;
    localparam logic [1:0] MSI_I = 2'b00, MSI_S = 2'b01, MSI_M = 2'b10;

    state_t      r_state;
    logic [1:0]  r_st   [0:3];
    logic        r_tag  [0:3];
    logic [3:0]  r_data [0:3];
    logic        r_instr;
    logic [2:0]  r_addr;
    logic [3:0]  r_wdata;
    logic [12:0] r_bus_prev;
    logic [1:0]  r_sup_cnt;
    logic [12:0] r_sup_pkt;
    logic [12:0] r_req_pkt;   // own packet before SUPPLY suppression; held while waiting
    logic [12:0] r_bus_out;
    logic [3:0]  r_data_out;
    logic        r_done;

    logic        w_new, w_is_reply, w_reply, w_snoop, w_shit, w_sup_start, w_sup_busy;
    logic [1:0]  w_sidx, w_idx, w_snp_st, w_lk_st;
    logic        w_hit, w_inv_stall, w_wb_ack, w_fill;
    logic [2:0]  w_victim_addr;
    logic [12:0] w_miss_pkt, w_own_nxt;

    // bus_in is level-held: only the first cycle of a new value is an event
    assign w_new      = (bus_in != r_bus_prev);
    assign w_is_reply = (bus_in[12:7] == 6'b001000);
    assign w_reply    = w_new && w_is_reply;
    assign w_snoop    = w_new && !w_is_reply && bus_in[10];
    assign w_sidx     = bus_in[5:4];
    assign w_shit     = w_snoop && (r_st[w_sidx] != MSI_I) && (r_tag[w_sidx] == bus_in[6]);

    always_comb begin
        w_snp_st    = r_st[w_sidx];
        w_sup_start = 1'b0;
        if (w_shit) begin
            if (r_st[w_sidx] == MSI_M && bus_in[9]) begin
                w_sup_start = 1'b1;
                w_snp_st    = MSI_S;
            end else if (r_st[w_sidx] == MSI_M && bus_in[8]) begin
                w_sup_start = 1'b1;
                w_snp_st    = MSI_I;
            end else if (r_st[w_sidx] == MSI_S && (bus_in[8] || bus_in[7])) begin
                w_snp_st    = MSI_I;
            end
        end
    end

    // bus_out is owned by SUPPLY next cycle if one starts now or has more than one cycle left
    assign w_sup_busy = w_sup_start || (r_sup_cnt > 2'd1);

    // Lookup sees the line state after this cycle's snoop update
    assign w_idx         = r_addr[1:0];
    assign w_lk_st       = (w_shit && w_sidx == w_idx) ? w_snp_st : r_st[w_idx];
    assign w_hit         = (w_lk_st != MSI_I) && (r_tag[w_idx] == r_addr[2]);
    // The one-cycle INV cannot be held for later, so a write hit on S waits in LOOKUP
    assign w_inv_stall   = w_sup_busy && w_hit && r_instr && (w_lk_st == MSI_S);
    // Victim tag survives invalidation, so it still names the write-back address in WB_WAIT
    assign w_victim_addr = {r_tag[w_idx], w_idx};
    assign w_miss_pkt    = r_instr ? {6'b001010, r_addr, r_wdata} : {6'b001100, r_addr, 4'b0000};
    assign w_wb_ack      = w_reply && (bus_in[6:4] == w_victim_addr);
    assign w_fill        = w_reply && (bus_in[6:4] == r_addr);

    always_comb begin
        w_own_nxt = 13'b0;
        case (r_state)
            S_LOOKUP: begin
                if (w_hit) begin
                    if (r_instr && w_lk_st == MSI_S && !w_inv_stall)
                        w_own_nxt = {6'b001001, r_addr, r_wdata};
                end else if (w_lk_st == MSI_M) begin
                    w_own_nxt = {6'b101000, w_victim_addr, r_data[w_idx]};
                end else begin
                    w_own_nxt = w_miss_pkt;
                end
            end
            S_WB_WAIT:   w_own_nxt = w_wb_ack ? w_miss_pkt : r_req_pkt;
            S_MISS_WAIT: w_own_nxt = w_fill ? 13'b0 : r_req_pkt;
            default:     w_own_nxt = 13'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                r_st[i]   <= MSI_I;
                r_tag[i]  <= 1'b0;
                r_data[i] <= 4'b0;
            end
            r_instr    <= 1'b0;
            r_addr     <= 3'b0;
            r_wdata    <= 4'b0;
            r_bus_prev <= 13'b0;
            r_sup_cnt  <= 2'd0;
            r_sup_pkt  <= 13'b0;
            r_req_pkt  <= 13'b0;
            r_bus_out  <= 13'b0;
            r_data_out <= 4'b0;
            r_done     <= 1'b0;
        end else begin
            r_bus_prev <= bus_in;
            r_done     <= 1'b0;
            r_req_pkt  <= w_own_nxt;

            // Snoop update first; FSM writes below to the same line override it
            if (w_shit)
                r_st[w_sidx] <= w_snp_st;

            if (w_sup_start) begin
                r_sup_cnt <= 2'd3;
                r_sup_pkt <= {6'b011000, bus_in[6:4], r_data[w_sidx]};
                r_bus_out <= {6'b011000, bus_in[6:4], r_data[w_sidx]};
            end else if (r_sup_cnt > 2'd1) begin
                r_sup_cnt <= r_sup_cnt - 2'd1;
                r_bus_out <= r_sup_pkt;
            end else begin
                r_sup_cnt <= 2'd0;
                r_bus_out <= w_own_nxt;
            end

            case (r_state)
                S_IDLE: begin
                    if (execute_instruction) begin
                        r_instr <= instruction;
                        r_addr  <= address;
                        r_wdata <= data_in;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (!r_instr) begin
                            r_data_out <= r_data[w_idx];
                            r_state    <= S_FINISH;
                        end else if (!w_inv_stall) begin
                            r_data[w_idx] <= r_wdata;
                            r_st[w_idx]   <= MSI_M;
                            r_data_out    <= r_wdata;
                            r_state       <= S_FINISH;
                        end
                    end else if (w_lk_st == MSI_M) begin
                        r_st[w_idx] <= MSI_I;
                        r_state     <= S_WB_WAIT;
                    end else begin
                        r_state <= S_MISS_WAIT;
                    end
                end
                S_WB_WAIT: begin
                    if (w_wb_ack)
                        r_state <= S_MISS_WAIT;
                end
                S_MISS_WAIT: begin
                    if (w_fill) begin
                        r_tag[w_idx]  <= r_addr[2];
                        r_data[w_idx] <= r_instr ? r_wdata : bus_in[3:0];
                        r_st[w_idx]   <= r_instr ? MSI_M : MSI_S;
                        r_data_out    <= r_instr ? r_wdata : bus_in[3:0];
                        r_state       <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus_out  = r_bus_out;
    assign data_out = r_data_out;
    assign done     = r_done;
endmodule

// File: tb/tb_snoop_cache_controller.sv
// Purpose   : directed self-checking bench for snoop_cache_controller.
// Latency   : outputs sampled 1 time unit after each rising clock edge.
// Backpress.: none; every wait is a fixed number of cycles.
module tb_snoop_cache_controller;
    logic        clock = 1'b0;
    logic        reset;
    logic [12:0] bus_in;
    logic        execute_instruction;
    logic        instruction;
    logic [2:0]  address;
    logic [3:0]  data_in;
    logic [3:0]  data_out;
    logic        done;
    logic [12:0] bus_out;

    int checks = 0;
    int errors = 0;

    snoop_cache_controller dut (
        .clock               (clock),
        .reset               (reset),
        .bus_in              (bus_in),
        .execute_instruction (execute_instruction),
        .instruction         (instruction),
        .address             (address),
        .data_in             (data_in),
        .data_out            (data_out),
        .done                (done),
        .bus_out             (bus_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Strobe is sampled at the next edge; returns with the DUT in LOOKUP
    task automatic strobe(input logic wr, input logic [2:0] a, input logic [3:0] d);
        execute_instruction = 1'b1;
        instruction         = wr;
        address             = a;
        data_in             = d;
        tick();
        execute_instruction = 1'b0;
    endtask

    initial begin
        reset = 1'b1; bus_in = 13'b0; execute_instruction = 1'b0;
        instruction = 1'b0; address = 3'd0; data_in = 4'd0;
        #12;
        check("rst_bus_out", bus_out, 13'b0);
        check("rst_done", done, 13'b0);
        check("rst_data_out", data_out, 13'b0);
        @(posedge clock); #1; reset = 1'b0;
        tick();

        // Read miss addr 5, filled with 9
        strobe(1'b0, 3'd5, 4'd0);
        tick();
        check("rd_miss_pkt", bus_out, {6'b001100, 3'd5, 4'd0});
        check("rd_miss_no_done", done, 13'b0);
        tick();
        check("rd_miss_hold", bus_out, {6'b001100, 3'd5, 4'd0});
        bus_in = {6'b001000, 3'd5, 4'd9};
        tick();
        check("fill_bus_clear", bus_out, 13'b0);
        check("fill_data_out", data_out, 13'd9);
        check("fill_done_late", done, 13'b0);
        tick();
        check("fill_done", done, 13'd1);
        tick();
        check("fill_done_pulse", done, 13'b0);

        // Read hit addr 5: done two cycles after strobe, no bus traffic
        strobe(1'b0, 3'd5, 4'd0);
        tick();
        check("rd_hit_bus", bus_out, 13'b0);
        check("rd_hit_early", done, 13'b0);
        tick();
        check("rd_hit_done", done, 13'd1);
        check("rd_hit_data", data_out, 13'd9);

        // Write hit on S: one-cycle INV, line becomes M
        strobe(1'b1, 3'd5, 4'd3);
        tick();
        check("wr_s_inv", bus_out, {6'b001001, 3'd5, 4'd3});
        tick();
        check("wr_s_inv_gone", bus_out, 13'b0);
        check("wr_s_done", done, 13'd1);
        check("wr_s_data", data_out, 13'd3);

        // Snooped read miss on M line: SUPPLY for exactly 3 cycles
        bus_in = {6'b001100, 3'd5, 4'd0};
        tick();
        check("sup_c1", bus_out, {6'b011000, 3'd5, 4'd3});
        tick();
        check("sup_c2", bus_out, {6'b011000, 3'd5, 4'd3});
        tick();
        check("sup_c3", bus_out, {6'b011000, 3'd5, 4'd3});
        tick();
        check("sup_end", bus_out, 13'b0);

        // Line now S: read hits, write hit emits INV again
        strobe(1'b0, 3'd5, 4'd0);
        tick();
        check("rd_s_bus", bus_out, 13'b0);
        tick();
        check("rd_s_data", data_out, 13'd3);
        strobe(1'b1, 3'd5, 4'd7);
        tick();
        check("wr_s2_inv", bus_out, {6'b001001, 3'd5, 4'd7});
        tick();
        check("wr_s2_done", done, 13'd1);

        // Conflict miss with M victim: write-back, ack, then read miss
        strobe(1'b0, 3'd1, 4'd0);
        tick();
        check("wb_pkt", bus_out, {6'b101000, 3'd5, 4'd7});
        bus_in = {6'b001000, 3'd1, 4'd5};
        tick();
        check("wb_wrong_ack", bus_out, {6'b101000, 3'd5, 4'd7});
        bus_in = {6'b001000, 3'd5, 4'd0};
        tick();
        check("wb_then_miss", bus_out, {6'b001100, 3'd1, 4'd0});
        bus_in = {6'b001000, 3'd1, 4'd4};
        tick();
        check("wb_fill_data", data_out, 13'd4);
        check("wb_fill_bus", bus_out, 13'b0);
        tick();
        check("wb_fill_done", done, 13'd1);
        strobe(1'b0, 3'd1, 4'd0);
        tick();
        check("rd1_hit_bus", bus_out, 13'b0);
        tick();
        check("rd1_hit_data", data_out, 13'd4);
        strobe(1'b1, 3'd1, 4'd2);
        tick();
        check("wr1_inv", bus_out, {6'b001001, 3'd1, 4'd2});
        tick();

        // SUPPLY pre-empts a pending miss packet; strobe outside IDLE ignored
        strobe(1'b0, 3'd2, 4'd0);
        tick();
        check("miss2_pkt", bus_out, {6'b001100, 3'd2, 4'd0});
        execute_instruction = 1'b1; instruction = 1'b1; address = 3'd3; data_in = 4'hF;
        bus_in = {6'b001010, 3'd1, 4'd0};
        tick();
        execute_instruction = 1'b0;
        check("sup_pre_c1", bus_out, {6'b011000, 3'd1, 4'd2});
        tick();
        tick();
        check("sup_pre_c3", bus_out, {6'b011000, 3'd1, 4'd2});
        tick();
        check("miss2_redrive", bus_out, {6'b001100, 3'd2, 4'd0});

        // Asynchronous reset while in MISS_WAIT
        #2 reset = 1'b1;
        #1;
        check("arst_bus", bus_out, 13'b0);
        check("arst_done", done, 13'b0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_done", done, 13'b0);
        check("post_rst_data", data_out, 13'b0);
        strobe(1'b0, 3'd5, 4'd0);
        tick();
        check("post_rst_miss", bus_out, {6'b001100, 3'd5, 4'd0});
        bus_in = {6'b001000, 3'd5, 4'd6};
        tick();
        tick();
        check("post_rst_done2", done, 13'd1);
        check("post_rst_data2", data_out, 13'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/snoop_cache_controller.md
# snoop_cache_controller

Per-CPU private cache controller that feeds one port of the two-CPU snooping bus. It holds a 4-line direct-mapped MSI write-back cache over the 8-word, 4-bit shared memory, services local read/write instructions, and issues miss, invalidate and write-back packets on `bus_out`. It consumes fill replies and the other CPU's forwarded packets on `bus_in`, supplying data from Modified lines when snooped.

## Interface
- No parameters. Geometry is fixed: 4 lines, index = `address[1:0]`, tag = `address[2]`, 4-bit data, per-line 2-bit MSI state (I=00, S=01, M=10).
- `clock`  in  1  single clock, all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `bus_in`  in  13  packet from bus. Fill reply when [12:7]=6'b001000; otherwise a snooped packet from the other CPU when [10]=1.
- `execute_instruction`  in  1  request strobe; sampled only in IDLE.
- `instruction`  in  1  0=read, 1=write.
- `address`  in  3  word address.
- `data_in`  in  4  write data.
- `data_out`  out  4  read result; for writes, the written value.
- `done`  out  1  one-cycle completion pulse.
- `bus_out`  out  13  [12]WB, [11]SUPPLY, [10]BCAST, [9]RD_MISS, [8]WR_MISS, [7]INV, [6:4]addr, [3:0]data.

## Operation
- Request FSM states: IDLE, LOOKUP, WB_WAIT, MISS_WAIT, FINISH.
- IDLE: `execute_instruction`=1 latches instruction/address/data_in and goes to LOOKUP. It is ignored in every other state.
- LOOKUP, read hit (state S/M, tag match): data_out <= line data, go to FINISH.
- LOOKUP, write hit M: line data <= data_in, go to FINISH.
- LOOKUP, write hit S: line data <= data_in, line -> M. Drive `bus_out` = {6'b001001, addr, data} for exactly one cycle, then FINISH.
- LOOKUP, miss with victim M: drive {6'b101000, victim addr, victim data} and go to WB_WAIT. The victim is set to I.
- LOOKUP, miss with victim I/S: drive the miss packet and go to MISS_WAIT. Read miss is {6'b001100, addr, 0}. Write miss is {6'b001010, addr, data}.
- WB_WAIT: on a fill reply with addr = victim addr (treated as ack, data ignored), drive the miss packet and go to MISS_WAIT.
- MISS_WAIT: on a fill reply with addr = request addr, install tag/data. Read -> S, data_out <= reply data. Write -> data_in stored, line -> M, data_out <= data_in. Go to FINISH.
- Replies with a non-matching addr are ignored.
- FINISH: done=1 for one cycle, `bus_out`=0, return to IDLE.
- `bus_in` is level-held. A packet is acted on only in the cycle it first differs from the previous-cycle registered copy. Replies are accepted only in WB_WAIT/MISS_WAIT.
- Snoop (new packet, [10]=1, not a reply) runs in every FSM state, only when the indexed line is valid and its tag matches:
  - RD_MISS on M: start a SUPPLY of {6'b011000, addr, line data}; line -> S.
  - WR_MISS on M: SUPPLY, then line -> I.
  - WR_MISS or INV on S: line -> I.
  - Otherwise: no action.
- SUPPLY packet is held on `bus_out` for exactly 3 cycles.
- SUPPLY has priority on `bus_out`. A pending own request packet is suppressed and re-driven afterwards, with the FSM state unchanged.
- Snoop and local access to the same line in the same cycle: the snoop state update is applied first, and the lookup uses the post-snoop state.

## Timing
- Reset values:
  - all lines I, tag 0, data 0
  - FSM IDLE, `bus_out`=13'b0, `done`=0, `data_out`=4'b0
  - SUPPLY counter 0, bus_in history 0
- Hit latency: strobe at edge N -> LOOKUP at N+1 -> `done` high in cycle after edge N+2.
- Write-hit-S: INV visible for the cycle after edge N+1; `done` one cycle later.
- Miss: request visible from the cycle after edge N+1 until the reply edge. `done` follows one cycle after the accepting reply edge.
- Reset mid-operation clears everything asynchronously. In-flight request and SUPPLY are dropped, with no `done`.

## Test plan
- Reset, read addr 5 -> `bus_out`={001100,101,0000}. Reply {001000,101,1001} -> `done` pulse, `data_out`=9, line 1 = S, tag 1.
- Read addr 5 again -> `done` 2 cycles after strobe, `data_out`=9, `bus_out` stays 0.
- Write addr 5 data 3 -> one-cycle `bus_out`={001001,101,0011}, line 1 = M, `done`.
- Snoop new `bus_in`={001100,101,0000} -> `bus_out`={011000,101,0011} for 3 cycles, line 1 -> S.
- With line 1 M (data 7), read addr 1 -> WB {101000,101,0111}. Ack reply addr 101 -> {001100,001,0000}. Reply data 4 -> `data_out`=4, line 1 S tag 0.
- Assert `reset` during MISS_WAIT -> `bus_out`=0 immediately, no `done`. The next read of addr 5 misses.
